// File: rtl/mips_pipe_ctrl_hazard_if.sv
// Bundle between the ID-stage decoder/datapath and the pipeline control + hazard unit.
// Carries ID-stage inputs in one direction and staged control / hazard outputs in the other.
interface mips_pipe_ctrl_hazard_if;
  localparam int unsigned CTRL_W = 13;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned MEM_W  = 4;
  localparam int unsigned WB_W   = 2;

  logic [CTRL_W-1:0] id_ctrl;
  logic              id_jr;
  logic              id_link;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              branch_taken;

  logic [CTRL_W-1:0] ex_ctrl;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_wreg;
  logic [MEM_W-1:0]  mem_ctrl;
  logic [REG_W-1:0]  mem_wreg;
  logic [WB_W-1:0]   wb_ctrl;
  logic [REG_W-1:0]  wb_wreg;
  logic              stall;
  logic              if_flush;
  logic [1:0]        forward_a;
  logic [1:0]        forward_b;

  // Decoder / datapath side.
  modport master (
    output id_ctrl, id_jr, id_link, id_rs, id_rt, id_rd, branch_taken,
    input  ex_ctrl, ex_rs, ex_rt, ex_wreg, mem_ctrl, mem_wreg, wb_ctrl, wb_wreg,
    input  stall, if_flush, forward_a, forward_b
  );

  // Control pipeline / hazard unit side.
  modport slave (
    input  id_ctrl, id_jr, id_link, id_rs, id_rt, id_rd, branch_taken,
    output ex_ctrl, ex_rs, ex_rt, ex_wreg, mem_ctrl, mem_wreg, wb_ctrl, wb_wreg,
    output stall, if_flush, forward_a, forward_b
  );
endinterface

// File: rtl/mips_pipe_ctrl_hazard.sv
// Control-word pipeline (ID/EX, EX/MEM, MEM/WB) with stall, flush and forwarding for a 5-stage MIPS.
// Build option MIPS_PIPE_FORWARDING_EN: defined = EX forwarding, load-use stalls only; undefined = no forwarding, stall on RAW.
module mips_pipe_ctrl_hazard #(
  parameter int unsigned LINK_REG = 31
) (
  input logic                   clk,
  input logic                   reset,
  mips_pipe_ctrl_hazard_if.slave bus
);
  localparam int unsigned CTRL_W = 13;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned MEM_W  = 4;
  localparam int unsigned WB_W   = 2;

  localparam int unsigned B_JUMP     = 12;
  localparam int unsigned B_REGDST   = 11;
  localparam int unsigned B_MEMTOREG = 9;
  localparam int unsigned B_MEMREAD  = 7;
  localparam int unsigned B_MEMWRITE = 6;
  localparam int unsigned M_REGWRITE = 2;

  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [REG_W-1:0]  r_ex_rs;
  logic [REG_W-1:0]  r_ex_rt;
  logic [REG_W-1:0]  r_ex_wreg;
  logic [MEM_W-1:0]  r_mem_ctrl;
  logic [REG_W-1:0]  r_mem_wreg;
  logic [WB_W-1:0]   r_wb_ctrl;
  logic [REG_W-1:0]  r_wb_wreg;

  logic              w_ex_hit;
  logic              w_load_use;
  logic              w_raw_hazard;
  logic              w_stall;
  logic              w_if_flush;
  logic              w_bubble;
  logic [REG_W-1:0]  w_id_wreg;
  logic [1:0]        w_forward_a;
  logic [1:0]        w_forward_b;

  // A non-zero destination that matches either ID source register.
  function automatic logic reg_hit(input logic [REG_W-1:0] wreg,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rt);
    return (wreg != '0) && ((wreg == rs) || (wreg == rt));
  endfunction

  assign w_ex_hit   = reg_hit(r_ex_wreg, bus.id_rs, bus.id_rt);
  assign w_load_use = r_ex_ctrl[B_MEMREAD] & w_ex_hit;

`ifdef MIPS_PIPE_FORWARDING_EN
  localparam int unsigned C_REGWRITE = 8;
  localparam int unsigned W_REGWRITE = 0;

  // EX/MEM result wins over MEM/WB; $0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic             mem_we,
                                         input logic [REG_W-1:0] mem_wreg,
                                         input logic             wb_we,
                                         input logic [REG_W-1:0] wb_wreg);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_we && (mem_wreg != '0) && (mem_wreg == src)) begin
      sel = 2'b10;
    end else if (wb_we && (wb_wreg != '0) && (wb_wreg == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    w_raw_hazard = 1'b0;
    w_forward_a  = 2'b00;
    w_forward_b  = 2'b00;
    if (!reset) begin
      w_forward_a = fwd_sel(r_ex_rs, r_mem_ctrl[M_REGWRITE], r_mem_wreg,
                            r_wb_ctrl[W_REGWRITE], r_wb_wreg);
      w_forward_b = fwd_sel(r_ex_rt, r_mem_ctrl[M_REGWRITE], r_mem_wreg,
                            r_wb_ctrl[W_REGWRITE], r_wb_wreg);
    end
  end

  // Sanity: EX should never see a load whose RegWrite is clear in this core.
  logic w_unused_regwrite;
  assign w_unused_regwrite = r_ex_ctrl[C_REGWRITE];
`else
  localparam int unsigned C_REGWRITE = 8;

  logic w_mem_hit;

  // Without bypass paths any producer still in EX or MEM blocks the reader in ID.
  assign w_mem_hit = reg_hit(r_mem_wreg, bus.id_rs, bus.id_rt);

  always_comb begin
    w_raw_hazard = (r_ex_ctrl[C_REGWRITE] & w_ex_hit) |
                   (r_mem_ctrl[M_REGWRITE] & w_mem_hit);
    w_forward_a  = 2'b00;
    w_forward_b  = 2'b00;
  end
`endif

  // A taken branch discards the ID instruction, so it never needs to stall.
  always_comb begin
    w_stall    = 1'b0;
    w_if_flush = 1'b0;
    if (!reset) begin
      w_stall    = ~bus.branch_taken & (w_load_use | w_raw_hazard);
      w_if_flush = bus.branch_taken |
                   ((bus.id_ctrl[B_JUMP] | bus.id_jr) & ~w_stall);
    end
  end

  assign w_bubble = w_stall | bus.branch_taken;

  // Destination select: JAL links to $31, R-type uses rd, everything else rt.
  always_comb begin
    w_id_wreg = bus.id_rt;
    if (bus.id_link) begin
      w_id_wreg = REG_W'(LINK_REG);
    end else if (bus.id_ctrl[B_REGDST]) begin
      w_id_wreg = bus.id_rd;
    end
  end

  // ID/EX: bubble on stall or taken branch; EX/MEM and MEM/WB always advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_ctrl  <= '0;
      r_ex_rs    <= '0;
      r_ex_rt    <= '0;
      r_ex_wreg  <= '0;
      r_mem_ctrl <= '0;
      r_mem_wreg <= '0;
      r_wb_ctrl  <= '0;
      r_wb_wreg  <= '0;
    end else begin
      if (w_bubble) begin
        r_ex_ctrl <= '0;
        r_ex_rs   <= '0;
        r_ex_rt   <= '0;
        r_ex_wreg <= '0;
      end else begin
        r_ex_ctrl <= bus.id_ctrl;
        r_ex_rs   <= bus.id_rs;
        r_ex_rt   <= bus.id_rt;
        r_ex_wreg <= w_id_wreg;
      end
      r_mem_ctrl <= r_ex_ctrl[B_MEMTOREG:B_MEMWRITE];
      r_mem_wreg <= r_ex_wreg;
      r_wb_ctrl  <= r_mem_ctrl[MEM_W-1:MEM_W-WB_W];
      r_wb_wreg  <= r_mem_wreg;
    end
  end

  assign bus.ex_ctrl   = r_ex_ctrl;
  assign bus.ex_rs     = r_ex_rs;
  assign bus.ex_rt     = r_ex_rt;
  assign bus.ex_wreg   = r_ex_wreg;
  assign bus.mem_ctrl  = r_mem_ctrl;
  assign bus.mem_wreg  = r_mem_wreg;
  assign bus.wb_ctrl   = r_wb_ctrl;
  assign bus.wb_wreg   = r_wb_wreg;
  assign bus.stall     = w_stall;
  assign bus.if_flush  = w_if_flush;
  assign bus.forward_a = w_forward_a;
  assign bus.forward_b = w_forward_b;
endmodule

// File: tb/tb_mips_pipe_ctrl_hazard.sv
// Directed bench for mips_pipe_ctrl_hazard; expectations follow the MIPS_PIPE_FORWARDING_EN build setting.
module tb_mips_pipe_ctrl_hazard;
  localparam logic [12:0] C_NOP = 13'b0_0_0_0_0_0_0_0_0_0000;
  localparam logic [12:0] C_ADD = 13'b0_1_0_0_1_0_0_0_0_0111;
  localparam logic [12:0] C_LW  = 13'b0_0_1_1_1_1_0_0_0_0000;
  localparam logic [12:0] C_J   = 13'b1_0_0_0_0_0_0_0_0_0000;
  localparam logic [12:0] C_JAL = 13'b1_0_0_0_1_0_0_0_0_0000;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mips_pipe_ctrl_hazard_if bus ();

  mips_pipe_ctrl_hazard #(.LINK_REG(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ex(input string tag, input logic [12:0] ctrl, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] wreg);
    chk({tag, ".ex_ctrl"}, 32'(bus.ex_ctrl), 32'(ctrl));
    chk({tag, ".ex_rs"},   32'(bus.ex_rs),   32'(rs));
    chk({tag, ".ex_rt"},   32'(bus.ex_rt),   32'(rt));
    chk({tag, ".ex_wreg"}, 32'(bus.ex_wreg), 32'(wreg));
  endtask

  task automatic chk_hz(input string tag, input logic st, input logic fl,
                        input logic [1:0] fa, input logic [1:0] fb);
    chk({tag, ".stall"},     32'(bus.stall),     32'(st));
    chk({tag, ".if_flush"},  32'(bus.if_flush),  32'(fl));
    chk({tag, ".forward_a"}, 32'(bus.forward_a), 32'(fa));
    chk({tag, ".forward_b"}, 32'(bus.forward_b), 32'(fb));
  endtask

  task automatic chk_mw(input string tag, input logic [3:0] mc, input logic [4:0] mw,
                        input logic [1:0] wc, input logic [4:0] ww);
    chk({tag, ".mem_ctrl"}, 32'(bus.mem_ctrl), 32'(mc));
    chk({tag, ".mem_wreg"}, 32'(bus.mem_wreg), 32'(mw));
    chk({tag, ".wb_ctrl"},  32'(bus.wb_ctrl),  32'(wc));
    chk({tag, ".wb_wreg"},  32'(bus.wb_wreg),  32'(ww));
  endtask

  task automatic id_in(input logic [12:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic jr, input logic link, input logic bt);
    bus.id_ctrl      = c;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_jr        = jr;
    bus.id_link      = link;
    bus.branch_taken = bt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    id_in(C_NOP, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    // Reset held two edges with an R-type and a taken branch in front of it.
    reset = 1'b1;
    id_in(C_ADD, 1, 2, 3, 0, 0, 1);
    chk_hz("rst_pre", 0, 0, 2'b00, 2'b00);
    tick();
    chk_ex("rst1", C_NOP, 0, 0, 0);
    chk_mw("rst1", 4'b0000, 0, 2'b00, 0);
    chk_hz("rst1", 0, 0, 2'b00, 2'b00);
    tick();
    chk_ex("rst2", C_NOP, 0, 0, 0);
    chk_mw("rst2", 4'b0000, 0, 2'b00, 0);

    // One R-type walks EX -> MEM -> WB, one stage per cycle.
    reset = 1'b0;
    id_in(C_ADD, 1, 2, 3, 0, 0, 0);
    chk_hz("lat_id", 0, 0, 2'b00, 2'b00);
    tick();
    chk_ex("lat_ex", C_ADD, 1, 2, 3);
    chk_mw("lat_ex", 4'b0000, 0, 2'b00, 0);
    id_in(C_NOP, 0, 0, 0, 0, 0, 0);
    tick();
    chk_ex("lat_mem", C_NOP, 0, 0, 0);
    chk_mw("lat_mem", 4'b0100, 3, 2'b00, 0);
    tick();
    chk_mw("lat_wb", 4'b0000, 0, 2'b01, 3);

    // Load-use: LW $8 then a reader of $8.
    id_in(C_LW, 1, 8, 0, 0, 0, 0);
    chk_hz("lu_lw_id", 0, 0, 2'b00, 2'b00);
    tick();
    chk_ex("lu_lw_ex", C_LW, 1, 8, 8);
    id_in(C_ADD, 8, 2, 10, 0, 0, 0);
    chk_hz("lu_stall", 1, 0, 2'b00, 2'b00);
    tick();
    chk_ex("lu_bubble", C_NOP, 0, 0, 0);
    chk_mw("lu_bubble", 4'b1110, 8, 2'b00, 0);
`ifdef MIPS_PIPE_FORWARDING_EN
    chk_hz("lu_release", 0, 0, 2'b00, 2'b00);
    tick();
    chk_ex("lu_dep_ex", C_ADD, 8, 2, 10);
    chk_mw("lu_dep_ex", 4'b0000, 0, 2'b11, 8);
    chk_hz("lu_dep_ex", 0, 0, 2'b01, 2'b00);
`else
    chk_hz("lu_stall2", 1, 0, 2'b00, 2'b00);
    tick();
    chk_ex("lu_bubble2", C_NOP, 0, 0, 0);
    chk_mw("lu_bubble2", 4'b0000, 0, 2'b11, 8);
    chk_hz("lu_release", 0, 0, 2'b00, 2'b00);
    tick();
    chk_ex("lu_dep_ex", C_ADD, 8, 2, 10);
    chk_hz("lu_dep_ex", 0, 0, 2'b00, 2'b00);
`endif

    // Back-to-back ALU dependency: ADD $5 then SUB $7,$5,$6.
    drain();
    id_in(C_ADD, 1, 2, 5, 0, 0, 0);
    tick();
    id_in(C_ADD, 5, 6, 7, 0, 0, 0);
`ifdef MIPS_PIPE_FORWARDING_EN
    chk_hz("b2b_id", 0, 0, 2'b00, 2'b00);
    tick();
    chk_ex("b2b_ex", C_ADD, 5, 6, 7);
    chk_hz("b2b_ex", 0, 0, 2'b10, 2'b00);
`else
    chk_hz("b2b_s1", 1, 0, 2'b00, 2'b00);
    tick();
    chk_ex("b2b_bub1", C_NOP, 0, 0, 0);
    chk_hz("b2b_s2", 1, 0, 2'b00, 2'b00);
    tick();
    chk_hz("b2b_go", 0, 0, 2'b00, 2'b00);
    tick();
    chk_ex("b2b_ex", C_ADD, 5, 6, 7);
    chk_hz("b2b_ex", 0, 0, 2'b00, 2'b00);
`endif

    // One-apart dependency on rt.
    drain();
    id_in(C_ADD, 1, 2, 5, 0, 0, 0);
    tick();
    id_in(C_NOP, 0, 0, 0, 0, 0, 0);
    tick();
    id_in(C_ADD, 6, 5, 7, 0, 0, 0);
`ifdef MIPS_PIPE_FORWARDING_EN
    chk_hz("gap_id", 0, 0, 2'b00, 2'b00);
    tick();
    chk_ex("gap_ex", C_ADD, 6, 5, 7);
    chk_hz("gap_ex", 0, 0, 2'b00, 2'b01);
`else
    chk_hz("gap_s1", 1, 0, 2'b00, 2'b00);
    tick();
    chk_hz("gap_go", 0, 0, 2'b00, 2'b00);
    tick();
    chk_ex("gap_ex", C_ADD, 6, 5, 7);
    chk_hz("gap_ex", 0, 0, 2'b00, 2'b00);
`endif

`ifdef MIPS_PIPE_FORWARDING_EN
    // Forward priority: MEM over WB, WB when MEM writes $0, nothing for $0.
    drain();
    id_in(C_ADD, 1, 2, 9, 0, 0, 0);   tick();
    id_in(C_ADD, 3, 4, 9, 0, 0, 0);   tick();
    id_in(C_ADD, 9, 9, 11, 0, 0, 0);  tick();
    chk_hz("fwd_mem", 0, 0, 2'b10, 2'b10);
    id_in(C_ADD, 1, 2, 9, 0, 0, 0);   tick();
    id_in(C_ADD, 1, 2, 0, 0, 0, 0);   tick();
    id_in(C_ADD, 9, 9, 12, 0, 0, 0);  tick();
    chk_mw("fwd_wb", 4'b0100, 0, 2'b01, 9);
    chk_hz("fwd_wb", 0, 0, 2'b01, 2'b01);
    id_in(C_ADD, 1, 2, 0, 0, 0, 0);   tick();
    id_in(C_ADD, 1, 2, 0, 0, 0, 0);   tick();
    id_in(C_ADD, 0, 0, 13, 0, 0, 0);  tick();
    chk_hz("fwd_r0", 0, 0, 2'b00, 2'b00);
`endif

    // Taken branch overrides a pending load-use stall.
    drain();
    id_in(C_LW, 1, 8, 0, 0, 0, 0);
    tick();
    id_in(C_ADD, 8, 2, 10, 0, 0, 0);
    chk_hz("br_pre", 1, 0, 2'b00, 2'b00);
    id_in(C_ADD, 8, 2, 10, 0, 0, 1);
    chk_hz("br_flush", 0, 1, 2'b00, 2'b00);
    tick();
    chk_ex("br_bubble", C_NOP, 0, 0, 0);
    chk_mw("br_bubble", 4'b1110, 8, 2'b00, 0);

    // Branch and jump together: branch flushes, jump is bubbled; JR flushes too.
    drain();
    id_in(C_J, 0, 0, 0, 0, 0, 1);
    chk_hz("brj", 0, 1, 2'b00, 2'b00);
    tick();
    chk_ex("brj_bubble", C_NOP, 0, 0, 0);
    id_in(C_J, 0, 0, 0, 0, 0, 0);
    chk_hz("j_only", 0, 1, 2'b00, 2'b00);
    tick();
    chk_ex("j_only_ex", C_J, 0, 0, 0);
    id_in(C_NOP, 0, 0, 0, 1, 0, 0);
    chk_hz("jr", 0, 1, 2'b00, 2'b00);
    id_in(C_NOP, 0, 0, 0, 0, 0, 0);
    chk_hz("no_jump", 0, 0, 2'b00, 2'b00);

    // Jump held by a load-use stall flushes only once released; then JAL links $31.
    drain();
    id_in(C_LW, 1, 8, 0, 0, 0, 0);
    tick();
    id_in(C_J, 8, 0, 0, 0, 0, 0);
    chk_hz("js_held", 1, 0, 2'b00, 2'b00);
    tick();
    chk_ex("js_bubble", C_NOP, 0, 0, 0);
`ifndef MIPS_PIPE_FORWARDING_EN
    chk_hz("js_held2", 1, 0, 2'b00, 2'b00);
    tick();
`endif
    chk_hz("js_flush", 0, 1, 2'b00, 2'b00);
    tick();
    chk_ex("js_ex", C_J, 8, 0, 0);
    id_in(C_JAL, 0, 0, 0, 0, 1, 0);
    chk_hz("jal_id", 0, 1, 2'b00, 2'b00);
    tick();
    chk_ex("jal_ex", C_JAL, 0, 0, 31);
    id_in(C_NOP, 0, 0, 0, 0, 0, 0);
    tick();
    chk_mw("jal_mem", 4'b0100, 31, 2'b00, 0);

    // Reset with work in flight discards every stage and masks hazard outputs.
    id_in(C_LW, 1, 8, 0, 0, 0, 0);
    tick();
    chk_ex("mid_lw", C_LW, 1, 8, 8);
    reset = 1'b1;
    id_in(C_ADD, 8, 2, 10, 1, 0, 1);
    chk_hz("mid_rst", 0, 0, 2'b00, 2'b00);
    tick();
    chk_ex("mid_rst", C_NOP, 0, 0, 0);
    chk_mw("mid_rst", 4'b0000, 0, 2'b00, 0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_pipe_ctrl_hazard.md
Name: mips_pipe_ctrl_hazard

Overview:
- Consumes the 13-bit control word produced by the ID-stage decoder and the ID register fields.
- Carries the control word down the ID/EX, EX/MEM and MEM/WB pipeline registers, inserting bubbles where needed.
- Generates load-use stall, IF flush and EX operand-forwarding selects.
- Sits between the decoder and the datapath pipeline registers of the 5-stage MIPS core.

Parameters:
- LINK_REG, 31, destination register written by JAL (id_link=1).
- CTRL_W, 13, control word width. Packing MSB..LSB: {Jump, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, BranchNE, BranchEQ, ALUOp[3:0]}.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears every pipeline stage.
- id_ctrl  in  13  decoder control word for the instruction in ID.
- id_jr  in  1  decoder JR flag for the instruction in ID.
- id_link  in  1  instruction in ID is JAL.
- id_rs, id_rt, id_rd  in  5 each  register fields of the instruction in ID.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- ex_ctrl  out  13  registered ID/EX control word.
- ex_rs, ex_rt  out  5 each  registered source fields.
- ex_wreg  out  5  EX destination register.
- mem_ctrl  out  4  {MemtoReg, RegWrite, MemRead, MemWrite}.
- mem_wreg  out  5  MEM destination register.
- wb_ctrl  out  2  {MemtoReg, RegWrite}.
- wb_wreg  out  5  WB destination register.
- stall  out  1  freeze PC and IF/ID; bubble into ID/EX.
- if_flush  out  1  zero the IF/ID register.
- forward_a, forward_b  out  2 each  EX operand select: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB.

Behaviour:
- Reset:
  - At the edge with reset=1, all registered outputs go to 0.
  - stall, if_flush, forward_a and forward_b are forced to 0 while reset=1.
  - Reset mid-instruction discards all in-flight stages; no partial retire.
- ID/EX update:
  - If stall or branch_taken: load bubble (ctrl=0, rs/rt/wreg=0).
  - Otherwise capture id_ctrl, id_rs and id_rt.
  - ex_wreg = LINK_REG if id_link; else id_rd if RegDst; else id_rt.
- EX/MEM and MEM/WB advance unconditionally every cycle; EX is never stalled.
  - mem_ctrl is taken from ex_ctrl bits.
  - wb_ctrl is taken from mem_ctrl[3:2].
- Latency: exactly 1 cycle per stage. An id_ctrl field appears on ex_ctrl 1 cycle later, mem_ctrl 2 cycles later, wb_ctrl 3 cycles later.
- Load-use stall (combinational on registered state): stall = ex MemRead & ex_wreg!=0 & (ex_wreg==id_rs | ex_wreg==id_rt).
  - Exactly 1 bubble per load-use pair.
  - Suppressed when branch_taken=1, because the flush discards the ID instruction anyway.
- IF flush: if_flush = branch_taken | ((id Jump | id_jr) & ~stall).
  - A jump held by a stall is re-presented next cycle and flushes then.
  - Simultaneous branch_taken and jump in ID: branch wins; the jump is bubbled.
- Forwarding, evaluated separately for ex_rs (forward_a) and ex_rt (forward_b):
  - 10 if mem RegWrite & mem_wreg!=0 & mem_wreg==src.
  - Else 01 if wb RegWrite & wb_wreg!=0 & wb_wreg==src.
  - Else 00.
  - EX/MEM has priority over MEM/WB.
  - $0 is never forwarded and never causes a stall.
- The register file writes before it reads, so WB never causes a stall.

Optional Feature:
- Macro: MIPS_PIPE_FORWARDING_EN.
- Defined: forwarding logic as above; stall only on load-use.
- Undefined:
  - forward_a and forward_b are tied to 00.
  - stall also asserts on any RAW against EX (RegWrite, ex_wreg!=0) or MEM (mem RegWrite, mem_wreg!=0) matching id_rs or id_rt.
  - A back-to-back dependency therefore costs 2 bubbles, and a 1-apart dependency costs 1 bubble.

Test Plan:
- Reset: hold reset 2 cycles with id_ctrl=R-type, branch_taken=1 -> all outputs 0 during reset and on the first edge after; with reset deasserted, id_ctrl=13'b01_001_00_00_0111 appears on ex_ctrl the next cycle, then mem_ctrl=4'b0100, then wb_ctrl=2'b01.
- Load-use: LW $8 (ex_wreg=8, MemRead=1) followed by ID id_rs=8 -> stall=1 for exactly 1 cycle, ex_ctrl=0 next cycle, then the dependent instruction enters EX with forward_a=01.
- Forwarding: ADD $9 in MEM and ADD $9 in WB, EX has ex_rs=9, ex_rt=9 -> forward_a=10, forward_b=10; change to mem_wreg=0, wb_wreg=9 -> both 01; writes to $0 -> 00.
- Branch flush: branch_taken=1 with a load-use condition present -> if_flush=1, stall=0, ex_ctrl=0 next cycle.
- Jump and stall together: J in ID with a load-use stall active -> if_flush=0 this cycle and =1 the following cycle; JAL captured with ex_wreg=31.
- Forwarding disabled (MIPS_PIPE_FORWARDING_EN undefined): ADD $5 then SUB using $5 -> stall asserted 2 consecutive cycles, forward_a=00 throughout.
